ethernet_header_extractor: RTL and testbench

//   Parametrised header stripper for the receive path. Collects the first HEADER_BYTES of each
//   AXI-Stream frame into a wide header register, then forwards the remaining payload as a

---
 rtl/ethernet_header_extractor.sv | 243 ++++++++++++++++++++++++
 tb/tb_ethernet_header_extractor.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_header_extractor.sv
// Receive-path header stripper: captures the first HEADER_BYTES of each AXI-Stream frame
// into a wide register and forwards the remaining payload realigned to lane 0.
module ethernet_header_extractor #(
    parameter int unsigned DATA_BYTES   = 8,
    parameter int unsigned HEADER_BYTES = 42
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_rx_axis_tvalid,
    input  logic [DATA_BYTES*8-1:0]   i_rx_axis_tdata,
    input  logic [DATA_BYTES-1:0]     i_rx_axis_tkeep,
    input  logic                      i_rx_axis_tlast,
    output logic                      o_rx_axis_tready,
    output logic [HEADER_BYTES*8-1:0] o_header,
    output logic                      o_header_valid,
    output logic                      o_header_err,
    output logic                      o_pl_tvalid,
    output logic [DATA_BYTES*8-1:0]   o_pl_tdata,
    output logic [DATA_BYTES-1:0]     o_pl_tkeep,
    output logic                      o_pl_tlast,
    input  logic                      i_pl_tready
);

    localparam int unsigned DW        = DATA_BYTES * 8;
    localparam int unsigned HW        = HEADER_BYTES * 8;
    localparam int unsigned OFF       = HEADER_BYTES % DATA_BYTES;
    localparam int unsigned HDR_BEATS = (HEADER_BYTES + DATA_BYTES - 1) / DATA_BYTES;
    localparam int unsigned NEED      = (OFF == 0) ? DATA_BYTES : OFF;
    localparam int unsigned CW        = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
    localparam int unsigned KW        = $clog2(DATA_BYTES + 1);

    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

    function automatic logic [KW-1:0] keep_count(input logic [DATA_BYTES-1:0] keep);
        logic [KW-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_BYTES; i++) n = n + KW'(keep[i]);
        return n;
    endfunction

    function automatic logic [DATA_BYTES-1:0] keep_mask(input logic [KW-1:0] n);
        logic [DATA_BYTES-1:0] m;
        for (int i = 0; i < DATA_BYTES; i++) m[i] = (KW'(i) < n);
        return m;
    endfunction

    function automatic logic [DW-1:0] lane_mask(input logic [DATA_BYTES-1:0] keep);
        logic [DW-1:0] m;
        for (int i = 0; i < DATA_BYTES; i++) m[i*8 +: 8] = {8{keep[i]}};
        return m;
    endfunction

    // Lane 0 (first on wire) becomes the most significant byte.
    function automatic logic [DW-1:0] byte_rev(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        for (int i = 0; i < DATA_BYTES; i++) r[(DATA_BYTES-1-i)*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [HW-1:0]       hdr_sr_q, hdr_sr_d;
    logic [HW-1:0]       header_q, header_d;
    logic                hdr_vld_q, hdr_vld_d;
    logic                hdr_err_q, hdr_err_d;
    logic [DW-1:0]       rsd_q, rsd_d;
    logic [KW-1:0]       rsd_cnt_q, rsd_cnt_d;
    logic                pl_vld_q, pl_vld_d;
    logic [DW-1:0]       pl_data_q, pl_data_d;
    logic [DATA_BYTES-1:0] pl_keep_q, pl_keep_d;
    logic                pl_last_q, pl_last_d;
    logic                run_q;

    logic                in_xfer;
    logic                out_free;
    logic                is_close;
    logic [KW-1:0]       in_cnt;
    logic [HW+DW-1:0]    hdr_ext;
    logic [HW-1:0]       hdr_shift;
    logic [HW-1:0]       hdr_full;
    logic [2*DW-1:0]     mrg;
    logic [DW-1:0]       pl_cat;
    logic                em;
    logic                em_last;
    logic [KW-1:0]       em_cnt;
    logic [DW-1:0]       em_data;
    logic [DATA_BYTES-1:0] em_keep;

    // run_q holds tready low while in reset.
    assign o_rx_axis_tready = run_q & ((state_q == ST_HEADER) |
                                       ((state_q == ST_PAYLOAD) & out_free));
    assign in_xfer  = i_rx_axis_tvalid & o_rx_axis_tready;
    assign out_free = ~pl_vld_q | i_pl_tready;
    assign is_close = (cnt_q == CW'(HDR_BEATS - 1));
    assign in_cnt   = keep_count(i_rx_axis_tkeep);

    assign hdr_ext   = {hdr_sr_q, byte_rev(i_rx_axis_tdata)};
    assign hdr_shift = HW'(hdr_ext);
    assign hdr_full  = HW'(hdr_ext >> ((DATA_BYTES - NEED) * 8));

    // rsd_q holds the previous raw beat; its lanes OFF.. are the residual bytes.
    assign mrg    = {i_rx_axis_tdata, rsd_q};
    assign pl_cat = DW'(mrg >> (OFF * 8));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hdr_sr_d  = hdr_sr_q;
        header_d  = header_q;
        hdr_vld_d = 1'b0;
        hdr_err_d = 1'b0;
        rsd_d     = rsd_q;
        rsd_cnt_d = rsd_cnt_q;
        pl_vld_d  = pl_vld_q & ~i_pl_tready;
        pl_data_d = pl_data_q;
        pl_keep_d = pl_keep_q;
        pl_last_d = pl_last_q;
        em        = 1'b0;
        em_last   = 1'b0;
        em_cnt    = '0;
        em_data   = '0;

        unique case (state_q)
            ST_HEADER: begin
                if (in_xfer) begin
                    if (!is_close) begin
                        if (i_rx_axis_tlast) begin
                            hdr_err_d = 1'b1;
                            cnt_d     = '0;
                        end else begin
                            hdr_sr_d = hdr_shift;
                            cnt_d    = cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_d = '0;
                        if (in_cnt < KW'(NEED)) begin
                            hdr_err_d = 1'b1;
                        end else begin
                            header_d  = hdr_full;
                            hdr_vld_d = 1'b1;
                            rsd_d     = i_rx_axis_tdata;
                            if (!i_rx_axis_tlast) begin
                                state_d   = ST_PAYLOAD;
                                rsd_cnt_d = KW'(DATA_BYTES - OFF);
                            end else if (in_cnt > KW'(NEED)) begin
                                state_d   = ST_FLUSH;
                                rsd_cnt_d = in_cnt - KW'(OFF);
                            end
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (in_xfer) begin
                    em = 1'b1;
                    if (OFF == 0) begin
                        em_data = i_rx_axis_tdata;
                        em_cnt  = in_cnt;
                        em_last = i_rx_axis_tlast;
                        if (i_rx_axis_tlast) state_d = ST_HEADER;
                    end else begin
                        rsd_d   = i_rx_axis_tdata;
                        em_data = pl_cat;
                        em_cnt  = KW'(DATA_BYTES);
                        if (!i_rx_axis_tlast) begin
                            rsd_cnt_d = KW'(DATA_BYTES - OFF);
                        end else if (in_cnt <= KW'(OFF)) begin
                            em_cnt  = KW'(DATA_BYTES - OFF) + in_cnt;
                            em_last = 1'b1;
                            state_d = ST_HEADER;
                        end else begin
                            rsd_cnt_d = in_cnt - KW'(OFF);
                            state_d   = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    em      = 1'b1;
                    em_data = pl_cat;
                    em_cnt  = rsd_cnt_q;
                    em_last = 1'b1;
                    state_d = ST_HEADER;
                end
            end
            default: state_d = ST_HEADER;
        endcase

        em_keep = keep_mask(em_cnt);
        if (em) begin
            pl_vld_d  = 1'b1;
            pl_keep_d = em_keep;
            pl_data_d = em_data & lane_mask(em_keep);
            pl_last_d = em_last;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_HEADER;
            cnt_q     <= '0;
            hdr_sr_q  <= '0;
            header_q  <= '0;
            hdr_vld_q <= 1'b0;
            hdr_err_q <= 1'b0;
            rsd_q     <= '0;
            rsd_cnt_q <= '0;
            pl_vld_q  <= 1'b0;
            pl_data_q <= '0;
            pl_keep_q <= '0;
            pl_last_q <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hdr_sr_q  <= hdr_sr_d;
            header_q  <= header_d;
            hdr_vld_q <= hdr_vld_d;
            hdr_err_q <= hdr_err_d;
            rsd_q     <= rsd_d;
            rsd_cnt_q <= rsd_cnt_d;
            pl_vld_q  <= pl_vld_d;
            pl_data_q <= pl_data_d;
            pl_keep_q <= pl_keep_d;
            pl_last_q <= pl_last_d;
            run_q     <= 1'b1;
        end
    end

    assign o_header       = header_q;
    assign o_header_valid = hdr_vld_q;
    assign o_header_err   = hdr_err_q;
    assign o_pl_tvalid    = pl_vld_q;
    assign o_pl_tdata     = pl_data_q;
    assign o_pl_tkeep     = pl_keep_q;
    assign o_pl_tlast     = pl_last_q;

endmodule

// File: tb/tb_ethernet_header_extractor.sv
// Bench for ethernet_header_extractor: a 42-byte-header instance (realigning) and a 16-byte one
// (pass-through), driven from a frame table and checked against a byte-level scoreboard.
module tb_ethernet_header_extractor;

    typedef struct packed {
        logic         err;
        logic [335:0] hdr;
    } hdr_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } pl_t;

    typedef struct {
        int sel;
        int len;
        int gap;
        bit rnd;
        bit exp_err;
        int exp_beats;
    } vec_t;

    logic         clk, rst_n;
    logic [63:0]  tdata;
    logic [7:0]   tkeep;
    logic         tlast, tvalid_a, tvalid_b, pl_ready;
    logic         tready_a, tready_b;
    logic [335:0] hdr_a;
    logic [127:0] hdr_b;
    logic         hv_a, he_a, pv_a, pt_a, hv_b, he_b, pv_b, pt_b;
    logic [63:0]  pd_a, pd_b;
    logic [7:0]   pk_a, pk_b;

    ethernet_header_extractor dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_rx_axis_tvalid(tvalid_a), .i_rx_axis_tdata(tdata), .i_rx_axis_tkeep(tkeep),
        .i_rx_axis_tlast(tlast), .o_rx_axis_tready(tready_a),
        .o_header(hdr_a), .o_header_valid(hv_a), .o_header_err(he_a),
        .o_pl_tvalid(pv_a), .o_pl_tdata(pd_a), .o_pl_tkeep(pk_a), .o_pl_tlast(pt_a),
        .i_pl_tready(pl_ready)
    );

    ethernet_header_extractor #(.DATA_BYTES(8), .HEADER_BYTES(16)) dut16 (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_rx_axis_tvalid(tvalid_b), .i_rx_axis_tdata(tdata), .i_rx_axis_tkeep(tkeep),
        .i_rx_axis_tlast(tlast), .o_rx_axis_tready(tready_b),
        .o_header(hdr_b), .o_header_valid(hv_b), .o_header_err(he_b),
        .o_pl_tvalid(pv_b), .o_pl_tdata(pd_b), .o_pl_tkeep(pk_b), .o_pl_tlast(pt_b),
        .i_pl_tready(pl_ready)
    );

    int errors = 0;
    int checks = 0;
    hdr_t hq_a[$], hq_b[$];
    pl_t  pq_a[$], pq_b[$];
    logic [335:0] last_hdr[2];
    int   nbeats[2];
    int   nerrs[2];
    bit   prev_stall[2];
    logic [73:0] prev_bus[2];
    bit   rnd_ready = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [335:0] act, input logic [335:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Downstream ready: steady 1 or random per cycle.
    initial begin
        pl_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pl_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic mon(input int sel, input logic hv, input logic he, input logic [335:0] hdr,
                       input logic pv, input logic [63:0] pd, input logic [7:0] pk,
                       input logic pt);
        hdr_t h;
        pl_t  p;
        bit   have;
        if (hv | he) begin
            have = (sel == 0) ? (hq_a.size() > 0) : (hq_b.size() > 0);
            checks++;
            if (!have) begin
                errors++;
                $display("FAIL hdr_unexpected[%0d]: got valid=%0b err=%0b required no pulse",
                         sel, hv, he);
            end else begin
                h = (sel == 0) ? hq_a.pop_front() : hq_b.pop_front();
                chk($sformatf("hdr_kind[%0d]", sel), 336'({hv, he}),
                    336'(h.err ? 2'b01 : 2'b10));
                chk($sformatf("hdr_val[%0d]", sel), hdr, h.hdr);
                if (he) nerrs[sel]++;
            end
        end
        if (pv & pl_ready) begin
            have = (sel == 0) ? (pq_a.size() > 0) : (pq_b.size() > 0);
            checks++;
            if (!have) begin
                errors++;
                $display("FAIL pl_unexpected[%0d]: got data=%0h keep=%0h last=%0b required none",
                         sel, pd, pk, pt);
            end else begin
                p = (sel == 0) ? pq_a.pop_front() : pq_b.pop_front();
                chk($sformatf("pl_data[%0d]", sel), 336'(pd), 336'(p.data));
                chk($sformatf("pl_keep[%0d]", sel), 336'(pk), 336'(p.keep));
                chk($sformatf("pl_last[%0d]", sel), 336'(pt), 336'(p.last));
            end
            nbeats[sel]++;
        end
        if (prev_stall[sel])
            chk($sformatf("pl_stable[%0d]", sel), 336'({pv, pd, pk, pt}), 336'(prev_bus[sel]));
        prev_stall[sel] = pv & ~pl_ready;
        prev_bus[sel]   = {pv, pd, pk, pt};
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, hv_a, he_a, hdr_a, pv_a, pd_a, pk_a, pt_a);
            mon(1, hv_b, he_b, 336'(hdr_b), pv_b, pd_b, pk_b, pt_b);
        end else begin
            prev_stall[0] = 1'b0;
            prev_stall[1] = 1'b0;
        end
    end

    task automatic send_beat(input int sel, input logic [63:0] d, input logic [7:0] k,
                             input logic l);
        int n;
        bit rdy;
        tdata = d;
        tkeep = k;
        tlast = l;
        if (sel == 0) tvalid_a = 1'b1; else tvalid_b = 1'b1;
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 1000) begin
            @(negedge clk);
            rdy = (sel == 0) ? tready_a : tready_b;
            n++;
        end
        if (!rdy) begin
            errors++;
            checks++;
            $display("FAIL tready_timeout[%0d]: got tready=0 for %0d cycles required 1", sel, n);
        end
        @(posedge clk);
        #1;
        tvalid_a = 1'b0;
        tvalid_b = 1'b0;
    endtask

    task automatic send_frame(input int sel, input int len, input bit rnd);
        logic [7:0]   fb[256];
        logic [335:0] h;
        logic [63:0]  d;
        logic [7:0]   k;
        hdr_t         he;
        pl_t          pe;
        int           hb, p, nb, idx;
        hb = (sel == 0) ? 42 : 16;
        for (int i = 0; i < len; i++) fb[i] = 8'($urandom);
        if (len < hb) begin
            he.err = 1'b1;
            he.hdr = last_hdr[sel];
        end else begin
            h = '0;
            for (int i = 0; i < hb; i++) h = (h << 8) | 336'(fb[i]);
            he.err = 1'b0;
            he.hdr = h;
            last_hdr[sel] = h;
            p = len - hb;
            for (int o = 0; o < p; o += 8) begin
                pe.data = '0;
                pe.keep = '0;
                for (int j = 0; j < 8; j++) begin
                    if (o + j < p) begin
                        pe.data[j*8 +: 8] = fb[hb + o + j];
                        pe.keep[j] = 1'b1;
                    end
                end
                pe.last = (o + 8 >= p);
                if (sel == 0) pq_a.push_back(pe); else pq_b.push_back(pe);
            end
        end
        if (sel == 0) hq_a.push_back(he); else hq_b.push_back(he);
        nb = (len + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            d = {$urandom, $urandom};
            k = '0;
            for (int j = 0; j < 8; j++) begin
                idx = b * 8 + j;
                if (idx < len) begin
                    d[j*8 +: 8] = fb[idx];
                    k[j] = 1'b1;
                end
            end
            if (rnd && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_beat(sel, d, k, b == nb - 1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((hq_a.size() + hq_b.size() + pq_a.size() + pq_b.size()) != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("drain_left", 336'(hq_a.size() + hq_b.size() + pq_a.size() + pq_b.size()), 336'(0));
    endtask

    vec_t vecs[22];

    initial begin
        int sum_b[2];
        int sum_e[2];
        vecs[0]  = '{0, 60, 2, 0, 0, 3};
        vecs[1]  = '{0, 42, 1, 0, 0, 0};
        vecs[2]  = '{0, 30, 1, 0, 1, 0};
        vecs[3]  = '{0, 60, 1, 0, 0, 3};
        vecs[4]  = '{0, 64, 0, 0, 0, 3};
        vecs[5]  = '{0, 60, 0, 1, 0, 3};
        vecs[6]  = '{0, 50, 0, 1, 0, 1};
        vecs[7]  = '{0, 45, 0, 1, 0, 1};
        vecs[8]  = '{0, 49, 0, 1, 0, 1};
        vecs[9]  = '{0, 43, 0, 1, 0, 1};
        vecs[10] = '{0, 100, 0, 1, 0, 8};
        vecs[11] = '{0, 41, 0, 1, 1, 0};
        vecs[12] = '{0, 8, 0, 1, 1, 0};
        vecs[13] = '{0, 130, 0, 1, 0, 11};
        vecs[14] = '{0, 42, 0, 1, 0, 0};
        vecs[15] = '{1, 40, 1, 0, 0, 3};
        vecs[16] = '{1, 16, 0, 0, 0, 0};
        vecs[17] = '{1, 12, 0, 0, 1, 0};
        vecs[18] = '{1, 20, 0, 1, 0, 1};
        vecs[19] = '{1, 5, 0, 1, 1, 0};
        vecs[20] = '{1, 41, 0, 1, 0, 4};
        vecs[21] = '{1, 17, 0, 1, 0, 1};

        rst_n = 1'b0;
        tvalid_a = 1'b0;
        tvalid_b = 1'b0;
        tdata = '0;
        tkeep = '0;
        tlast = 1'b0;
        last_hdr[0] = '0;
        last_hdr[1] = '0;
        nbeats = '{0, 0};
        nerrs = '{0, 0};
        sum_b = '{0, 0};
        sum_e = '{0, 0};

        repeat (3) @(negedge clk);
        chk("rst_tready_a", 336'(tready_a), 336'(0));
        chk("rst_tready_b", 336'(tready_b), 336'(0));
        chk("rst_header_a", hdr_a, 336'(0));
        chk("rst_hv_he_a", 336'({hv_a, he_a}), 336'(0));
        chk("rst_pl_a", 336'({pv_a, pd_a, pk_a, pt_a}), 336'(0));
        chk("rst_pl_b", 336'({pv_b, pd_b, pk_b, pt_b}), 336'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            rnd_ready = vecs[i].rnd;
            send_frame(vecs[i].sel, vecs[i].len, vecs[i].rnd);
            sum_b[vecs[i].sel] += vecs[i].exp_beats;
            sum_e[vecs[i].sel] += int'(vecs[i].exp_err);
            repeat (vecs[i].gap) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        chk("beats_a", 336'(nbeats[0]), 336'(sum_b[0]));
        chk("beats_b", 336'(nbeats[1]), 336'(sum_b[1]));
        chk("errs_a", 336'(nerrs[0]), 336'(sum_e[0]));
        chk("errs_b", 336'(nerrs[1]), 336'(sum_e[1]));

        // Reset in the middle of a header: frame discarded, no error pulse, clean restart.
        rnd_ready = 0;
        send_beat(0, 64'h0706050403020100, 8'hFF, 1'b0);
        send_beat(0, 64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0);
        send_beat(0, 64'h1716151413121110, 8'hFF, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_tready", 336'(tready_a), 336'(0));
        chk("midrst_header", hdr_a, 336'(0));
        chk("midrst_out", 336'({hv_a, he_a, pv_a}), 336'(0));
        last_hdr[0] = '0;
        last_hdr[1] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rnd_ready = 1;
        send_frame(0, 60, 1'b1);
        send_frame(0, 64, 1'b1);
        send_frame(1, 40, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
